// File: rtl/matrix_3x3_gen.sv
// rtl/matrix_3x3_gen.sv - streaming 3x3 neighbourhood generator with two circular line buffers
module matrix_3x3_gen #(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] m11,
  output logic [DATA_WIDTH-1:0] m12,
  output logic [DATA_WIDTH-1:0] m13,
  output logic [DATA_WIDTH-1:0] m21,
  output logic [DATA_WIDTH-1:0] m22,
  output logic [DATA_WIDTH-1:0] m23,
  output logic [DATA_WIDTH-1:0] m31,
  output logic [DATA_WIDTH-1:0] m32,
  output logic [DATA_WIDTH-1:0] m33,
  output logic                  frame_done
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] EDGE_MIN = CNT_WIDTH'(2);

  logic [CNT_WIDTH-1:0]  col, row;
  logic [CNT_WIDTH-1:0]  col_eff, row_eff;
  logic [AW-1:0]         lb_idx;
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_a, lb_b;

  // in_sof forces the beat itself to (0,0), so position is resolved combinationally
  always_comb begin
    col_eff = in_sof ? '0 : col;
    row_eff = in_sof ? '0 : row;
    lb_idx  = col_eff[AW-1:0];
    lb_a    = lb2[lb_idx];
    lb_b    = lb1[lb_idx];
  end

  // Line buffers hold no reset: stale rows are always masked by the row>=2 rule
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2[lb_idx] <= lb_b;
      lb1[lb_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      m11 <= '0; m12 <= '0; m13 <= '0;
      m21 <= '0; m22 <= '0; m23 <= '0;
      m31 <= '0; m32 <= '0; m33 <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        out_valid  <= (row_eff >= EDGE_MIN) && (col_eff >= EDGE_MIN);
        frame_done <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        m11 <= m12; m12 <= m13; m13 <= lb_a;
        m21 <= m22; m22 <= m23; m23 <= lb_b;
        m31 <= m32; m32 <= m33; m33 <= in_data;
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + CNT_WIDTH'(1);
        end else begin
          col <= col_eff + CNT_WIDTH'(1);
          row <= row_eff;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb/tb_matrix_3x3_gen.sv - directed/random bench for matrix_3x3_gen against an image-array reference
module tb_matrix_3x3_gen;

  localparam int DW = 10;
  localparam int W  = 16;
  localparam int H  = 16;

  logic clk_tb = 1'b0;
  logic tb_rst;
  logic in_valid, in_sof;
  logic [DW-1:0] in_data;
  logic out_valid, frame_done;
  logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;

  always #5 clk_tb = ~clk_tb;

  matrix_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(10)) dut (
    .clk(clk_tb), .rst_n(tb_rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid),
    .m11(m11), .m12(m12), .m13(m13), .m21(m21), .m22(m22), .m23(m23),
    .m31(m31), .m32(m32), .m33(m33), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mr = 0, mc = 0, last_r = 0, last_c = 0;
  int pulses = 0, fds = 0;
  bit held = 1'b1;
  logic [DW-1:0]   img [H][W];
  logic [9*DW-1:0] exp_win = '0;
  logic [9*DW-1:0] first_win;

  function automatic logic [9*DW-1:0] dut_win();
    return {m11, m12, m13, m21, m22, m23, m31, m32, m33};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive a beat, update the image model, check 1 ns after the edge
  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    bit ev, efd;
    int r, c;
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk_tb);
    ev = 1'b0; efd = 1'b0;
    if (v) begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      img[r][c] = d;
      last_r = r; last_c = c;
      ev  = (r >= 2) && (c >= 2);
      efd = (r == H-1) && (c == W-1);
      if (ev)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[(8-(i*3+j))*DW +: DW] = img[r-2+i][c-2+j];
      held = ev;
      mc = (c == W-1) ? 0 : c + 1;
      mr = (c == W-1) ? ((r == H-1) ? 0 : r + 1) : r;
    end
    #1;
    chk("out_valid", {127'd0, out_valid}, {127'd0, ev});
    chk("frame_done", {127'd0, frame_done}, {127'd0, efd});
    if (ev) chk("window", {38'd0, dut_win()}, {38'd0, exp_win});
    else if (!v && held) chk("hold", {38'd0, dut_win()}, {38'd0, exp_win});
    pulses += int'(out_valid);
    fds    += int'(frame_done);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic ramp_frame(input bit sof, input int offset, input int max_gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, sof && r == 0 && c == 0, DW'(r*16 + c + offset));
        if (last_r == 2 && last_c == 2 && offset == 0)
          chk("first_win", {38'd0, dut_win()}, {38'd0, first_win});
        repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0, DW'($urandom_range(0, 1023)));
      end
  endtask

  initial begin
    first_win = {10'd0, 10'd1, 10'd2, 10'd16, 10'd17, 10'd18, 10'd32, 10'd33, 10'd34};
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    tb_rst = 1'b0;
    repeat (2) @(posedge clk_tb);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_frame_done", {127'd0, frame_done}, 128'd0);
    chk("rst_window", {38'd0, dut_win()}, 128'd0);
    @(negedge clk_tb);
    tb_rst = 1'b1;

    // Continuous ramp frame, with explicit line-wrap checks on row 3
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, r == 0 && c == 0, DW'(r*16 + c));
        if (r == 2 && c == 2) chk("first_win", {38'd0, dut_win()}, {38'd0, first_win});
        if (r == 3 && c == 2) begin
          chk("wrap_m11", {118'd0, m11}, 128'd16);
          chk("wrap_m22", {118'd0, m22}, 128'd33);
          chk("wrap_m33", {118'd0, m33}, 128'd50);
        end
        if (r == H-1 && c == W-1) begin
          chk("last_m22", {118'd0, m22}, 128'd238);
          chk("last_m33", {118'd0, m33}, 128'd255);
        end
      end
    step(1'b0, 1'b0, '0);
    chk("f1_pulses", 128'(pulses), 128'd196);
    chk("f1_done", 128'(fds), 128'd1);

    // Throttled ramp frame with random idle gaps
    pulses = 0; fds = 0;
    ramp_frame(1'b1, 0, 2);
    chk("thr_pulses", 128'(pulses), 128'd196);
    chk("thr_done", 128'(fds), 128'd1);

    // Random frame interrupted by in_sof at (5,7)
    step(1'b1, 1'b1, DW'($urandom_range(0, 1023)));
    while (!(mr == 5 && mc == 7)) step(1'b1, 1'b0, DW'($urandom_range(0, 1023)));
    pulses = 0; fds = 0;
    ramp_frame(1'b1, 0, 0);
    chk("sof_pulses", 128'(pulses), 128'd196);
    chk("sof_done", 128'(fds), 128'd1);

    // Random frame interrupted by async reset after (8,8)
    step(1'b1, 1'b1, DW'($urandom_range(0, 1023)));
    while (!(last_r == 8 && last_c == 8)) step(1'b1, 1'b0, DW'($urandom_range(0, 1023)));
    #1 tb_rst = 1'b0;
    #1;
    chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_frame_done", {127'd0, frame_done}, 128'd0);
    chk("arst_window", {38'd0, dut_win()}, 128'd0);
    #2 tb_rst = 1'b1;
    mr = 0; mc = 0; exp_win = '0; held = 1'b1;
    pulses = 0; fds = 0;
    ramp_frame(1'b0, 0, 1);
    chk("arst_pulses", 128'(pulses), 128'd196);

    // Back-to-back frames, second frame offset by 256
    pulses = 0; fds = 0;
    ramp_frame(1'b1, 0, 0);
    ramp_frame(1'b1, 256, 0);
    step(1'b0, 1'b0, '0);
    chk("b2b_pulses", 128'(pulses), 128'd392);
    chk("b2b_done", 128'(fds), 128'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
